gol_row_fetcher: RTL and testbench

- Stage between the Game of Life board memory and the VGA pixel colouring logic.
- During horizontal blanking it prefetches the next 64-cell board row over a request/grant read port into a back line buffer, then swaps buffers at end of line.
- During active video it delivers one registered `cell_alive` bit per pixel, so the pixel path no longer indexes the board array combinationally.

---
 rtl/gol_pkg.sv | 31 +++
 rtl/gol_row_fetcher_if.sv | 13 +
 rtl/gol_line_buffer.sv | 36 +++
 rtl/gol_row_fetcher.sv | 148 ++++++++++++++
 tb/tb_gol_row_fetcher.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gol_pkg.sv
// Shared constants and types for the Game of Life row fetcher: board geometry,
// VGA timing points and the fetch FSM state encoding.
package gol_pkg;

  localparam int unsigned LOG_W      = 6;
  localparam int unsigned LOG_H      = 5;
  localparam int unsigned CELL_SHIFT = 3;

  localparam int unsigned ROW_CELLS  = 1 << LOG_W;
  localparam int unsigned CELL_IDX_W = LOG_W + LOG_H;
  localparam int unsigned POP_W      = CELL_IDX_W + 1;
  localparam int unsigned PIX_W      = 10;

  typedef logic [PIX_W-1:0] pix_t;

  localparam pix_t FRAME_X0    = 10'd64;
  localparam pix_t FRAME_Y0    = 10'd112;
  localparam pix_t H_ACTIVE    = 10'd640;
  localparam pix_t H_TOTAL     = 10'd800;
  localparam pix_t V_TOTAL     = 10'd525;
  localparam pix_t FRAME_W_PIX = pix_t'(1 << (LOG_W + CELL_SHIFT));
  localparam pix_t FRAME_H_PIX = pix_t'(1 << (LOG_H + CELL_SHIFT));

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDrain,
    StReady
  } fetch_state_e;

endpackage

// File: rtl/gol_row_fetcher_if.sv
// Board memory read port: request/grant handshake, data one cycle after grant.
interface gol_row_fetcher_if;
  import gol_pkg::*;

  logic                  rd_req;
  logic [CELL_IDX_W-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_data;

  modport master (output rd_req, output rd_addr, input rd_gnt, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_gnt, output rd_data);

endinterface

// File: rtl/gol_line_buffer.sv
// Double-buffered board row: fetch writes the back half, the pixel path reads the
// front half, and a swap strobe exchanges them.
module gol_line_buffer
  import gol_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [LOG_W-1:0] wr_addr,
  input  logic             wr_data,
  input  logic             swap,
  input  logic [LOG_W-1:0] front_idx,
  output logic             front_bit
);

  logic [ROW_CELLS-1:0] buf_q [2];
  logic                 front_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      front_sel_q <= 1'b0;
    end else begin
      if (wr_en) begin
        buf_q[~front_sel_q][wr_addr] <= wr_data;
      end
      if (swap) begin
        front_sel_q <= ~front_sel_q;
      end
    end
  end

  assign front_bit = buf_q[front_sel_q][front_idx];

endmodule

// File: rtl/gol_row_fetcher.sv
// Prefetches the next board row during hblank and serves one registered cell bit
// per pixel. Define GOL_ROW_FETCH_POPCOUNT_EN to count live cells per frame.
module gol_row_fetcher
  import gol_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  pix_t              pix_x,
  input  pix_t              pix_y,
  gol_row_fetcher_if.master rd,
  output logic              cell_alive,
  output logic              fetch_busy,
  output logic              underrun,
  output logic [POP_W-1:0]  pop_count
);

  fetch_state_e     state_q;
  logic [LOG_H-1:0] row_q;
  logic [LOG_W-1:0] col_q;
  logic             cap_en_q;
  logic [LOG_W-1:0] cap_col_q;
  logic             underrun_q;

  pix_t             next_line, line_off, x_off, y_off;
  logic             trigger, swap_pt, swap, in_x, in_y, front_bit;
  logic [LOG_W-1:0] front_idx;

  always_comb begin
    next_line = (pix_y == V_TOTAL - 10'd1) ? '0 : pix_y + 10'd1;
    line_off  = next_line - FRAME_Y0;
    // Fetch only ahead of the first line of each cell row.
    trigger   = (pix_x == H_ACTIVE) && (next_line >= FRAME_Y0) &&
                (line_off < FRAME_H_PIX) && (line_off[CELL_SHIFT-1:0] == '0);
    swap_pt   = (pix_x == H_TOTAL - 10'd1);
    swap      = swap_pt && (state_q == StReady);
    x_off     = pix_x - FRAME_X0;
    y_off     = pix_y - FRAME_Y0;
    in_x      = (pix_x >= FRAME_X0) && (x_off < FRAME_W_PIX);
    in_y      = (pix_y >= FRAME_Y0) && (y_off < FRAME_H_PIX);
    front_idx = x_off[CELL_SHIFT +: LOG_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      cap_en_q   <= 1'b0;
      cap_col_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      cap_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            row_q   <= line_off[CELL_SHIFT +: LOG_H];
            col_q   <= '0;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (rd.rd_gnt) begin
            cap_en_q  <= 1'b1;
            cap_col_q <= col_q;
            col_q     <= col_q + 1'b1;
            if (col_q == '1) begin
              state_q <= StDrain;
            end
          end
          // Abort overrides any grant taken on the swap cycle.
          if (swap_pt) begin
            state_q    <= StIdle;
            underrun_q <= 1'b1;
          end
        end
        StDrain: begin
          if (swap_pt) begin
            state_q    <= StIdle;
            underrun_q <= 1'b1;
          end else begin
            state_q <= StReady;
          end
        end
        StReady: begin
          if (swap_pt) begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  gol_line_buffer u_line_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (cap_en_q),
    .wr_addr   (cap_col_q),
    .wr_data   (rd.rd_data),
    .swap      (swap),
    .front_idx (front_idx),
    .front_bit (front_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_alive <= 1'b0;
    end else begin
      cell_alive <= (in_x && in_y) ? front_bit : 1'b0;
    end
  end

  assign rd.rd_req   = (state_q == StReq);
  assign rd.rd_addr  = {row_q, col_q};
  assign fetch_busy  = (state_q != StIdle);
  assign underrun    = underrun_q;

`ifdef GOL_ROW_FETCH_POPCOUNT_EN
  logic [LOG_W:0]   row_acc_q;
  logic [POP_W-1:0] frame_acc_q;
  logic [POP_W-1:0] pop_q;

  // Row totals join the frame sum only when the row actually swaps in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_acc_q   <= '0;
      frame_acc_q <= '0;
      pop_q       <= '0;
    end else begin
      if ((state_q == StIdle) && trigger) begin
        row_acc_q <= '0;
      end else if (cap_en_q && rd.rd_data) begin
        row_acc_q <= row_acc_q + 1'b1;
      end
      if ((pix_x == '0) && (pix_y == '0)) begin
        pop_q       <= frame_acc_q;
        frame_acc_q <= '0;
      end else if (swap) begin
        frame_acc_q <= frame_acc_q + POP_W'(row_acc_q);
      end
    end
  end

  assign pop_count = pop_q;
`else
  assign pop_count = '0;
`endif

endmodule

// File: tb/tb_gol_row_fetcher.sv
// Self-checking bench for gol_row_fetcher: a behavioural board/row model predicts
// every pixel's cell bit, the fetch address sequence and the underrun flag.
module tb_gol_row_fetcher;
  import gol_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [9:0]       pix_x, pix_y;
  logic             cell_alive, fetch_busy, underrun;
  logic [POP_W-1:0] pop_count;

  gol_row_fetcher_if rd_if ();

  gol_row_fetcher dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .rd         (rd_if),
    .cell_alive (cell_alive),
    .fetch_busy (fetch_busy),
    .underrun   (underrun),
    .pop_count  (pop_count)
  );

  always #5 clk = ~clk;

  int          errors;
  int          checks;
  logic [63:0] board [32];
  logic [63:0] front_model;
  bit          exp_underrun;
  bit          pend;
  logic [10:0] pend_addr;
  bit          prev_valid;
  int          prev_x, prev_y;
  int          grants, last_gx, first_req_x, req_cycles, cur_row;

  function automatic bit exp_cell(input int x, input int y);
    if (x >= 64 && x < 64 + 512 && y >= 112 && y < 112 + 256) return front_model[(x - 64) / 8];
    return 1'b0;
  endfunction

  function automatic int next_of(input int y);
    return (y == 524) ? 0 : y + 1;
  endfunction

  function automatic bit fetch_line(input int y);
    int nl;
    nl = next_of(y);
    return (nl >= 112) && (nl < 112 + 256) && (((nl - 112) % 8) == 0);
  endfunction

  // One pixel clock: serve read data, check the previous pixel, present the next.
  task automatic tick(input int x, input int y, input bit g);
    logic       e;
    logic [10:0] exp_a;
    @(negedge clk);
    rd_if.rd_data = pend ? board[pend_addr[10:6]][pend_addr[5:0]] : 1'($urandom);
    pend = 1'b0;
    if (prev_valid) begin
      e = exp_cell(prev_x, prev_y);
      checks++;
      if (cell_alive !== e) begin
        errors++;
        $display("FAIL cell_alive x=%0d y=%0d got=%b exp=%b", prev_x, prev_y, cell_alive, e);
      end
      if (prev_x == 799) begin
        checks++;
        if (fetch_busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_after_swap y=%0d got=%b exp=0", prev_y, fetch_busy);
        end
        checks++;
        if (underrun !== exp_underrun) begin
          errors++;
          $display("FAIL underrun y=%0d got=%b exp=%b", prev_y, underrun, exp_underrun);
        end
      end
    end
    if (rd_if.rd_req === 1'b1) begin
      req_cycles++;
      if (first_req_x < 0) first_req_x = x;
    end
    if (rd_if.rd_req === 1'b1 && g) begin
      exp_a = {5'(cur_row), 6'(grants)};
      checks++;
      if (rd_if.rd_addr !== exp_a) begin
        errors++;
        $display("FAIL rd_addr grant=%0d got=%h exp=%h", grants, rd_if.rd_addr, exp_a);
      end
      pend      = 1'b1;
      pend_addr = rd_if.rd_addr;
      grants++;
      last_gx   = x;
    end
    rd_if.rd_gnt = g;
    pix_x = 10'(x);
    pix_y = 10'(y);
    prev_x = x;
    prev_y = y;
    prev_valid = 1'b1;
  endtask

  // mode: 0 always grant, 1 random grant, 2 ten-cycle stall mid-fetch, 3 no grant in hblank
  task automatic run_line(input int y, input int mode, input bit want_complete,
                          input int stop_grants);
    bit          f, g, complete;
    logic [10:0] held;
    f = fetch_line(y);
    cur_row = f ? (next_of(y) - 112) / 8 : 0;
    grants = 0; last_gx = -1; first_req_x = -1; req_cycles = 0; held = '0;
    for (int x = 0; x < 800; x++) begin
      case (mode)
        0:       g = 1'b1;
        1:       g = ($urandom_range(0, 9) < 7);
        2:       g = !(x >= 680 && x < 690);
        default: g = (x < 640);
      endcase
      tick(x, y, g);
      if (f && x == 700) begin
        checks++;
        if (fetch_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid_fetch y=%0d got=%b exp=1", y, fetch_busy);
        end
      end
      if (mode == 2 && x == 680) held = rd_if.rd_addr;
      if (mode == 2 && x == 689) begin
        checks++;
        if (rd_if.rd_req !== 1'b1 || rd_if.rd_addr !== held) begin
          errors++;
          $display("FAIL stall_hold req=%b addr=%h exp req=1 addr=%h", rd_if.rd_req,
                   rd_if.rd_addr, held);
        end
      end
      if (stop_grants != 0 && grants == stop_grants) return;
    end
    if (f) begin
      checks++;
      // Request registers one clock after the launch column is presented.
      if (first_req_x != 641) begin
        errors++;
        $display("FAIL rd_req_start y=%0d got=%0d exp=641", y, first_req_x);
      end
      // Grant at x leaves DRAIN at x+1, so READY at the swap column needs x <= 797.
      complete = (grants == 64) && (last_gx <= 797);
      checks++;
      if (complete != want_complete) begin
        errors++;
        $display("FAIL fetch_done y=%0d grants=%0d last=%0d exp_done=%b", y, grants, last_gx,
                 want_complete);
      end
      if (complete) front_model = board[cur_row];
      else exp_underrun = 1'b1;
    end else begin
      checks++;
      if (req_cycles != 0) begin
        errors++;
        $display("FAIL no_fetch_req y=%0d got=%0d cycles exp=0", y, req_cycles);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix_x = '0; pix_y = '0; rd_if.rd_gnt = 1'b0; rd_if.rd_data = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rd_if.rd_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", rd_if.rd_req); end
    checks++; if (rd_if.rd_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", rd_if.rd_addr); end
    checks++; if (cell_alive !== 1'b0) begin errors++; $display("FAIL reset_cell got=%b exp=0", cell_alive); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", fetch_busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    checks++; if (pop_count !== '0) begin errors++; $display("FAIL reset_pop got=%0d exp=0", pop_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_corner_cells();
    for (int r = 0; r < 32; r++) board[r] = '0;
    board[0][0]  = 1'b1;
    board[0][63] = 1'b1;
    run_line(111, 0, 1'b1, 0);
    run_line(112, 1, 1'b0, 0);
  endtask

  task automatic test_random_rows();
    int r;
    for (int i = 0; i < 32; i++) board[i] = {$urandom, $urandom};
    for (int k = 0; k < 4; k++) begin
      r = $urandom_range(1, 30);
      run_line(111 + 8 * r, 1, 1'b1, 0);
      run_line(112 + 8 * r + $urandom_range(0, 6), 1, 1'b0, 0);
    end
  endtask

  task automatic test_non_boundary();
    run_line(199, 1, 1'b1, 0);
    run_line(200, 1, 1'b0, 0);
    run_line(201, 1, 1'b0, 0);
  endtask

  task automatic test_short_stall();
    run_line(111 + 8 * 20, 2, 1'b1, 0);
    run_line(112 + 8 * 20, 1, 1'b0, 0);
  endtask

  task automatic test_long_stall();
    run_line(111 + 8 * 3, 3, 1'b0, 0);
    run_line(112 + 8 * 3, 1, 1'b0, 0);
  endtask

  task automatic test_reset_mid_fetch();
    run_line(111 + 8 * 5, 0, 1'b1, 30);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rd_if.rd_req !== 1'b0) begin errors++; $display("FAIL midrst_req got=%b exp=0", rd_if.rd_req); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", fetch_busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL midrst_underrun got=%b exp=0", underrun); end
    checks++; if (rd_if.rd_addr !== '0) begin errors++; $display("FAIL midrst_addr got=%h exp=0", rd_if.rd_addr); end
    front_model = '0; exp_underrun = 1'b0; pend = 1'b0; prev_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_line(112 + 8 * 7, 1, 1'b0, 0);
    run_line(111 + 8 * 9, 1, 1'b1, 0);
    run_line(112 + 8 * 9, 1, 1'b0, 0);
  endtask

  task automatic test_popcount();
`ifdef GOL_ROW_FETCH_POPCOUNT_EN
    int exp_pop;
    exp_pop = 0;
    for (int r = 0; r < 32; r++) begin
      board[r] = r[0] ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
      exp_pop += $countones(board[r]);
    end
    tick(0, 0, 1'b0);
    for (int r = 0; r < 32; r++) run_line(111 + 8 * r, 1, 1'b1, 0);
    tick(0, 0, 1'b0);
    tick(0, 400, 1'b0);
    checks++;
    if (pop_count !== POP_W'(exp_pop)) begin
      errors++;
      $display("FAIL pop_count got=%0d exp=%0d", pop_count, exp_pop);
    end
`else
    checks++;
    if (pop_count !== '0) begin
      errors++;
      $display("FAIL pop_count_off got=%0d exp=0", pop_count);
    end
`endif
  endtask

  initial begin
    errors = 0; checks = 0;
    front_model = '0; exp_underrun = 1'b0; pend = 1'b0; pend_addr = '0; prev_valid = 1'b0;
    prev_x = 0; prev_y = 0; grants = 0; last_gx = -1; first_req_x = -1; req_cycles = 0;
    cur_row = 0;
    for (int r = 0; r < 32; r++) board[r] = '0;
    test_reset();
    test_corner_cells();
    test_random_rows();
    test_non_boundary();
    test_short_stall();
    test_long_stall();
    test_reset_mid_fetch();
    test_popcount();
    tick(0, 400, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
